luma_out_stage: RTL and testbench

//   Output stage directly downstream of the Y-calculation DSP chain. Y = Kr*(R-G) + Kb*(B-G) + G.
//   - Tracks pixel valid through the free-running DSP latency.
//   - Rounds and saturates the 32-bit signed DSP result to an 8-bit luma.
//   - Tags each pixel with frame position (sof/eol/eof).
//   - Buffers results in a 2-entry skid buffer with ready/valid output.

---
 rtl/luma_pkg.sv | 30 +++
 rtl/luma_if.sv | 16 +
 rtl/luma_skid_buf.sv | 75 +++++++
 rtl/luma_out_stage.sv | 150 +++++++++++++++
 tb/tb_luma_out_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/luma_pkg.sv
// Shared definitions for the luma output stage.
//   PIX_W / TAG_W  : luma pixel width and tag width
//   tag_t          : {sof, eol, eof} frame-position tag layout
//   pix_t          : buffered word = {y, tag}
//   buf_state_t    : skid buffer occupancy states
//   FRAC_BITS_DEF  : default Q-format fractional bits of the DSP result
package luma_pkg;

  localparam int unsigned PIX_W         = 8;
  localparam int unsigned TAG_W         = 3;
  localparam int unsigned FRAC_BITS_DEF = 16;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  typedef struct packed {
    logic [PIX_W-1:0] y;
    tag_t             tag;
  } pix_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_t;

endpackage

// File: rtl/luma_if.sv
// Ready/valid luma stream: one pixel plus its frame-position tags.
//   valid, y, sof, eol, eof : driven by the producer (master)
//   ready                   : driven by the consumer (slave)
interface luma_if
  import luma_pkg::*;
();
  logic             valid;
  logic             ready;
  logic [PIX_W-1:0] y;
  logic             sof;
  logic             eol;
  logic             eof;

  modport master (output valid, y, sof, eol, eof, input ready);
  modport slave  (input valid, y, sof, eol, eof, output ready);
endinterface

// File: rtl/luma_skid_buf.sv
// Two-entry FIFO skid buffer for tagged luma pixels.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : offer wr_data this cycle
//   wr_data    : pixel + tags (PIX_W+TAG_W bits)
//   full       : both entries occupied
//   rd         : ready/valid output stream (master)
// A write is accepted when not full, or when full and an entry is popped in
// the same cycle; otherwise it is ignored (the caller flags the drop).
module luma_skid_buf
  import luma_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  pix_t   wr_data,
  output logic   full,
  luma_if.master rd
);

  buf_state_t state, state_nx;
  pix_t       head, tail;
  logic       pop, wr;

  assign pop  = rd.valid & rd.ready;
  assign wr   = wr_en & ((state != BUF_FULL) | pop);
  assign full = (state == BUF_FULL);

  assign rd.valid = (state != BUF_EMPTY);
  assign rd.y     = head.y;
  assign rd.sof   = head.tag.sof;
  assign rd.eol   = head.tag.eol;
  assign rd.eof   = head.tag.eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BUF_EMPTY: if (wr) state_nx = BUF_ONE;
      BUF_ONE: begin
        if (wr && !pop)      state_nx = BUF_FULL;
        else if (!wr && pop) state_nx = BUF_EMPTY;
      end
      BUF_FULL:  if (pop && !wr) state_nx = BUF_ONE;
      default:   state_nx = BUF_EMPTY;
    endcase
  end

  // head is always the oldest entry, so the output never moves while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        BUF_EMPTY: if (wr) head <= wr_data;
        BUF_ONE: begin
          if (wr && pop) head <= wr_data;
          else if (wr)   tail <= wr_data;
        end
        BUF_FULL: begin
          if (pop) begin
            head <= tail;
            if (wr) tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/luma_out_stage.sv
// Output stage after the Y-calculation DSP chain (Y = Kr*(R-G) + Kb*(B-G) + G).
// Tracks pixel valid through the DSP latency, rounds/saturates the Q-format
// result to 8 bits, tags frame position and buffers into a 2-entry skid FIFO.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid             : pixel applied to DSP inputs this cycle
//   p_in                 : signed DSP result, valid DSP_LAT cycles after in_valid
//   out_valid/out_ready  : output handshake
//   out_y                : rounded, saturated luma
//   out_sof/eol/eof      : frame-position tags
//   ovf, ovf_clr         : sticky drop flag and its synchronous clear
//   sat_hi_cnt/lo_cnt    : per-frame clip counters
// Optional feature macro LUMA_SAT_CNT_EN builds the clip counters; when it is
// undefined both counter ports are tied to zero.
module luma_out_stage
  import luma_pkg::*;
#(
  parameter int unsigned DSP_LAT   = 5,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [31:0] p_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_y,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic [15:0]        sat_hi_cnt,
  output logic [15:0]        sat_lo_cnt
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic signed [32:0] HALF = 33'sd1 <<< (FRAC_BITS - 1);

  logic [DSP_LAT-1:0] vpipe;
  logic               capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int unsigned i = 1; i < DSP_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  assign capture = vpipe[DSP_LAT-1];

  // 33-bit sum so +HALF can never wrap a large positive p_in.
  logic signed [32:0] rsum, ywide;
  logic               sat_hi, sat_lo;
  logic [PIX_W-1:0]   ysat;

  always_comb begin
    rsum   = $signed({p_in[31], p_in}) + HALF;
    ywide  = rsum >>> FRAC_BITS;
    sat_lo = ywide[32];
    sat_hi = !ywide[32] && (ywide > 33'sd255);
    if (sat_lo)      ysat = '0;
    else if (sat_hi) ysat = '1;
    else             ysat = ywide[PIX_W-1:0];
  end

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  tag_t             tag;
  logic             col_last, row_last;

  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign tag.sof  = (col == '0) && (row == '0);
  assign tag.eol  = col_last;
  assign tag.eof  = col_last && row_last;

  // Counters advance on every capture, dropped or not, to stay source-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (capture) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  luma_if buf_if ();
  logic   buf_full;
  pix_t   wr_pix;

  assign wr_pix.y   = ysat;
  assign wr_pix.tag = tag;

  luma_skid_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture),
    .wr_data (wr_pix),
    .full    (buf_full),
    .rd      (buf_if)
  );

  assign buf_if.ready = out_ready;
  assign out_valid    = buf_if.valid;
  assign out_y        = buf_if.y;
  assign out_sof      = buf_if.sof;
  assign out_eol      = buf_if.eol;
  assign out_eof      = buf_if.eof;

  // While full, out_valid is high, so a pop happens exactly when out_ready is.
  logic drop;
  assign drop = capture & buf_full & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef LUMA_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (capture) begin
      if (tag.sof) begin
        sat_hi_cnt <= {15'd0, sat_hi};
        sat_lo_cnt <= {15'd0, sat_lo};
      end else begin
        if (sat_hi && (sat_hi_cnt != '1)) sat_hi_cnt <= sat_hi_cnt + 16'd1;
        if (sat_lo && (sat_lo_cnt != '1)) sat_lo_cnt <= sat_lo_cnt + 16'd1;
      end
    end
  end
`else
  assign sat_hi_cnt = '0;
  assign sat_lo_cnt = '0;
`endif

endmodule

// File: tb/tb_luma_out_stage.sv
module tb_luma_out_stage;
  import luma_pkg::*;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 2;
  localparam int unsigned LAT = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] p_in = '0;
  logic               out_ready = 1'b0;
  logic               ovf_clr = 1'b0;
  logic               out_valid, out_sof, out_eol, out_eof, ovf;
  logic [7:0]         out_y;
  logic [15:0]        sat_hi_cnt, sat_lo_cnt;

  luma_if mon ();
  assign mon.valid = out_valid;
  assign mon.y     = out_y;
  assign mon.sof   = out_sof;
  assign mon.eol   = out_eol;
  assign mon.eof   = out_eof;
  assign mon.ready = out_ready;

  luma_out_stage #(.DSP_LAT(LAT), .FRAC_BITS(16), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .p_in       (p_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .sat_hi_cnt (sat_hi_cnt),
    .sat_lo_cnt (sat_lo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int val; } slot_t;
  typedef struct { int y; bit sof; bit eol; bit eof; } exp_t;

  slot_t lat_q[$];
  exp_t  exp_q[$];
  int    n_pix;
  bit    ovf_m;
  int    hi_m, lo_m;
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: floor((p + 0.5*2^16) / 2^16), then clip to [0,255].
  function automatic int ref_luma(input int p, output bit hi, output bit lo);
    longint s, q;
    s = longint'(p) + 64'sd32768;
    if (s >= 0) q = s / 65536;
    else        q = -((-s + 65535) / 65536);
    hi = (q > 255);
    lo = (q < 0);
    if (hi) return 255;
    if (lo) return 0;
    return int'(q);
  endfunction

  task automatic model_clear();
    slot_t z;
    z.v = 1'b0;
    z.val = 0;
    exp_q.delete();
    lat_q.delete();
    for (int i = 0; i < int'(LAT); i++) lat_q.push_back(z);
    n_pix = 0;
    ovf_m = 1'b0;
    hi_m  = 0;
    lo_m  = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit v, input int val, input bit rdy, input bit clr);
    slot_t s, f;
    exp_t  e;
    bit    pop, drop, hi, lo;
    int    pos, col, row;
    s.v = v;
    s.val = val;
    lat_q.push_back(s);
    f = lat_q.pop_front();
    in_valid  = v;
    p_in      = f.val;
    out_ready = rdy;
    ovf_clr   = clr;
    @(negedge clk);
    check("valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("y",   mon.y,   exp_q[0].y);
      check("sof", mon.sof, exp_q[0].sof);
      check("eol", mon.eol, exp_q[0].eol);
      check("eof", mon.eof, exp_q[0].eof);
    end
    check("ovf", ovf, ovf_m);
`ifdef LUMA_SAT_CNT_EN
    check("sat_hi", sat_hi_cnt, hi_m);
    check("sat_lo", sat_lo_cnt, lo_m);
`else
    check("sat_hi", sat_hi_cnt, 0);
    check("sat_lo", sat_lo_cnt, 0);
`endif
    @(posedge clk);
    pop  = (exp_q.size() != 0) && rdy;
    drop = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (f.v) begin
      pos   = n_pix % int'(W * H);
      col   = pos % int'(W);
      row   = pos / int'(W);
      e.y   = ref_luma(f.val, hi, lo);
      e.sof = (pos == 0);
      e.eol = (col == int'(W) - 1);
      e.eof = e.eol && (row == int'(H) - 1);
      n_pix++;
      if (exp_q.size() < 2) exp_q.push_back(e);
      else drop = 1'b1;
      if (e.sof) begin
        hi_m = hi ? 1 : 0;
        lo_m = lo ? 1 : 0;
      end else begin
        if (hi && hi_m < 65535) hi_m++;
        if (lo && lo_m < 65535) lo_m++;
      end
    end
    if (drop)     ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    #1;
  endtask

  // Called just after a rising edge; reset is applied between edges.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_y",     out_y, 0);
    check("rst_tags",  {out_sof, out_eol, out_eof}, 0);
    check("rst_ovf",   ovf, 0);
    check("rst_sat",   {sat_hi_cnt, sat_lo_cnt}, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rand_p();
    int base;
    base = int'($urandom_range(0, 340)) - 20;
    return base * 65536 + int'($urandom_range(0, 65535));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Latency: single pulse, capture DSP_LAT later, visible one cycle after.
    cycle(1'b1, 100 << 16, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
    check("lat_early", out_valid, 0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("lat_valid", out_valid, 1);
    check("lat_y", out_y, 100);
    check("lat_sof", out_sof, 1);
    repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);

    // Rounding / saturation corners.
    cycle(1'b1, 32'h0000_8000, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_7FFF, 1'b1, 1'b0);
    cycle(1'b1, -5 <<< 16,     1'b1, 1'b0);
    cycle(1'b1, 300 << 16,     1'b1, 1'b0);
    repeat (LAT + 3) cycle(1'b0, 0, 1'b1, 1'b0);
`ifdef LUMA_SAT_CNT_EN
    check("sat_hi_dir", sat_hi_cnt, 1);
    check("sat_lo_dir", sat_lo_cnt, 1);
`endif

    // Tags over a full 4x2 frame plus the first pixel of the next frame.
    do_reset();
    repeat (W * H + 1) cycle(1'b1, rand_p(), 1'b1, 1'b0);
    repeat (LAT + 3) cycle(1'b0, 0, 1'b1, 1'b0);

    // Backpressure: third capture into a full buffer is dropped.
    do_reset();
    cycle(1'b1, 10 << 16, 1'b0, 1'b0);
    cycle(1'b1, 20 << 16, 1'b0, 1'b0);
    cycle(1'b1, 30 << 16, 1'b0, 1'b0);
    repeat (LAT + 2) cycle(1'b0, 0, 1'b0, 1'b0);
    check("bp_ovf", ovf, 1);
    check("bp_head", out_y, 10);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("bp_second", out_y, 20);
    repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check("bp_clr", ovf, 0);

    // Full buffer with simultaneous pop and capture each cycle.
    do_reset();
    for (int i = 0; i < int'(LAT) + 8; i++)
      cycle(i < 8, rand_p(), i >= int'(LAT) + 2, 1'b0);
    repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
    check("full_flow_ovf", ovf, 0);

    // Randomized traffic, including overflow and clear.
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rand_p(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0);
    repeat (LAT + 3) cycle(1'b0, 0, 1'b1, 1'b0);

    // Reset mid-frame with two pixels buffered and one in flight.
    do_reset();
    cycle(1'b1, 40 << 16, 1'b0, 1'b0);
    cycle(1'b1, 41 << 16, 1'b0, 1'b0);
    cycle(1'b1, 42 << 16, 1'b0, 1'b0);
    repeat (LAT - 1) cycle(1'b0, 0, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    do_reset();
    cycle(1'b1, 50 << 16, 1'b1, 1'b0);
    repeat (LAT) cycle(1'b0, 0, 1'b1, 1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_sof", out_sof, 1);
    check("post_rst_y", out_y, 50);
    repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
